// File: rtl/rtc_lectura_seq_pkg.sv
// Shared definitions for the RTC time-readout sequencer.
//   T_PH / T_GAP : clocks per ADDR/DATA phase and per idle gap
//   N_XFER       : transactions per sequence (1 command + 9 reads)
//   ADDR_ROM     : register address of each transaction, index 0 = command
//   CMD_DATA     : byte written in the command transaction
//   phase_t      : bus-cycle engine states, seq_t : sequencer states
package rtc_pkg;

  localparam int T_PH   = 8;
  localparam int T_GAP  = 2;
  localparam int N_XFER = 10;

  localparam logic [7:0] CMD_DATA = 8'h00;

  // Packed, so entry 0 (the command address) is the rightmost byte.
  localparam logic [N_XFER-1:0][7:0] ADDR_ROM = {
    8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'hF0
  };

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_ADDR,
    PH_GAP1,
    PH_DATA,
    PH_GAP2
  } phase_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_FIN
  } seq_t;

  // Out-of-range indices return 0 instead of reading past the table.
  function automatic logic [7:0] xfer_addr(input logic [3:0] idx);
    logic [7:0] a;
    a = 8'h00;
    if (idx < 4'(N_XFER)) a = ADDR_ROM[idx];
    return a;
  endfunction

endpackage

// File: rtl/rtc_lectura_seq_if.sv
// RTC multiplexed AD bus.
//   ad_in  : byte from the RTC        ad_out : byte driven to the RTC
//   ad_oe  : 1 = drive ad_out         a_d    : 0 = address, 1 = data phase
//   cs, rd, wr : active-low strobes
// master = the sequencer side, slave = the RTC / bus model side.
interface rtc_lectura_seq_if;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       a_d;
  logic       cs;
  logic       rd;
  logic       wr;

  modport master (input ad_in, output ad_out, ad_oe, a_d, cs, rd, wr);
  modport slave  (output ad_in, input ad_out, ad_oe, a_d, cs, rd, wr);
endinterface

// File: rtl/rtc_lectura_seq_bus_cycle.sv
// Phase timing engine: one ADDR -> GAP1 -> DATA -> GAP2 transaction per
// accepted request. A request is taken while idle or on the last GAP2
// clock, so consecutive transactions run with no dead cycle.
//   i_req / i_wr / i_addr / i_wdata : request, 1 = write, address, write byte
//   o_rdata  : byte captured on the last DATA clock of a read
//   o_rvalid : one-cycle pulse (first GAP2 clock) when o_rdata is fresh
//   o_done   : high on the last clock of the transaction
//   bus      : RTC bus, all strobes driven from flops
module rtc_bus_cycle
  import rtc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req,
  input  logic       i_wr,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_rvalid,
  output logic       o_done,
  rtc_lectura_seq_if.master bus
);

  phase_t     r_state, w_state_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic       r_wr, r_cs, r_rd, r_wr_n, r_a_d, r_oe, r_rvalid;
  logic [7:0] r_addr, r_wdata, r_ad_out, r_rdata;
  logic       w_last, w_accept, w_capture;
  logic       w_cs, w_rd, w_wr_n, w_a_d, w_oe;
  logic [7:0] w_ad_out;

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      PH_ADDR, PH_DATA: w_last = (r_cnt == 4'(T_PH - 1));
      PH_GAP1, PH_GAP2: w_last = (r_cnt == 4'(T_GAP - 1));
      default:          w_last = 1'b0;
    endcase
  end

  assign o_done    = (r_state == PH_GAP2) && w_last;
  assign w_accept  = i_req && ((r_state == PH_IDLE) || o_done);
  assign w_capture = (r_state == PH_DATA) && w_last && !r_wr;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PH_IDLE: if (w_accept) w_state_next = PH_ADDR;
      PH_ADDR: if (w_last)   w_state_next = PH_GAP1;
      PH_GAP1: if (w_last)   w_state_next = PH_DATA;
      PH_DATA: if (w_last)   w_state_next = PH_GAP2;
      PH_GAP2: if (w_last)   w_state_next = w_accept ? PH_ADDR : PH_IDLE;
      default:               w_state_next = PH_IDLE;
    endcase
    // The counter restarts on every phase change, GAP2 -> ADDR included.
    if ((w_state_next != r_state) || (r_state == PH_IDLE)) w_cnt_next = 4'd0;
    else                                                   w_cnt_next = r_cnt + 4'd1;
  end

  // Bus outputs are decoded from the next state and registered, so the
  // pins change exactly on the phase boundary with no decode glitches.
  always_comb begin
    w_cs     = 1'b1;
    w_rd     = 1'b1;
    w_wr_n   = 1'b1;
    w_a_d    = 1'b0;
    w_oe     = 1'b0;
    w_ad_out = 8'h00;
    case (w_state_next)
      PH_ADDR: begin
        w_cs     = 1'b0;
        w_wr_n   = 1'b0;
        w_oe     = 1'b1;
        w_ad_out = w_accept ? i_addr : r_addr;
      end
      PH_DATA: begin
        w_cs  = 1'b0;
        w_a_d = 1'b1;
        if (r_wr) begin
          w_wr_n   = 1'b0;
          w_oe     = 1'b1;
          w_ad_out = r_wdata;
        end else begin
          w_rd = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= PH_IDLE;
      r_cnt    <= 4'd0;
      r_wr     <= 1'b0;
      r_addr   <= 8'h00;
      r_wdata  <= 8'h00;
      r_cs     <= 1'b1;
      r_rd     <= 1'b1;
      r_wr_n   <= 1'b1;
      r_a_d    <= 1'b0;
      r_oe     <= 1'b0;
      r_ad_out <= 8'h00;
      r_rdata  <= 8'h00;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      if (w_accept) begin
        r_wr    <= i_wr;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      r_cs     <= w_cs;
      r_rd     <= w_rd;
      r_wr_n   <= w_wr_n;
      r_a_d    <= w_a_d;
      r_oe     <= w_oe;
      r_ad_out <= w_ad_out;
      if (w_capture) r_rdata <= bus.ad_in;
      r_rvalid <= w_capture;
    end
  end

  assign bus.cs     = r_cs;
  assign bus.rd     = r_rd;
  assign bus.wr     = r_wr_n;
  assign bus.a_d    = r_a_d;
  assign bus.ad_oe  = r_oe;
  assign bus.ad_out = r_ad_out;
  assign o_rdata    = r_rdata;
  assign o_rvalid   = r_rvalid;

endmodule

// File: rtl/rtc_lectura_seq.sv
// RTC time-readout sequencer: on start, one command write (0xF0 <- 0x00)
// followed by nine register reads; each read byte goes to RAM slot 0..8.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle request, honoured only when idle
//   bus        : RTC AD bus (master side)
//   ram_addr / ram_wdata / ram_we : RAM write port, ram_we one cycle wide
//   busy       : sequence in progress, done : one-cycle end pulse
module rtc_lectura_seq
  import rtc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  rtc_lectura_seq_if.master bus,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       ram_we,
  output logic       busy,
  output logic       done
);

  seq_t       r_seq, w_seq_next;
  logic [3:0] r_idx, w_idx_next, r_ram_addr;
  logic       r_busy, r_done, w_req, w_xfer_done, w_rvalid;
  logic [7:0] w_rdata;

  // The next request is issued on the same clock the current transaction
  // finishes, so the engine chains straight into the next ADDR phase.
  always_comb begin
    w_seq_next = r_seq;
    w_idx_next = r_idx;
    w_req      = 1'b0;
    case (r_seq)
      SEQ_IDLE: begin
        if (start) begin
          w_seq_next = SEQ_RUN;
          w_idx_next = 4'd0;
          w_req      = 1'b1;
        end
      end
      SEQ_RUN: begin
        if (w_xfer_done) begin
          if (r_idx == 4'(N_XFER - 1)) begin
            w_seq_next = SEQ_FIN;
          end else begin
            w_idx_next = r_idx + 4'd1;
            w_req      = 1'b1;
          end
        end
      end
      SEQ_FIN:  w_seq_next = SEQ_IDLE;
      default:  w_seq_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq      <= SEQ_IDLE;
      r_idx      <= 4'd0;
      r_ram_addr <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_seq  <= w_seq_next;
      r_idx  <= w_idx_next;
      // Transaction n (n >= 1) reads RAM slot n-1; the slot is held for the
      // whole transaction so it is stable under the engine's write pulse.
      if (w_req && (w_idx_next != 4'd0)) r_ram_addr <= w_idx_next - 4'd1;
      r_busy <= (w_seq_next == SEQ_RUN);
      r_done <= (w_seq_next == SEQ_FIN);
    end
  end

  rtc_bus_cycle u_bus_cycle (
    .clk      (clk),
    .reset    (reset),
    .i_req    (w_req),
    .i_wr     (w_idx_next == 4'd0),
    .i_addr   (xfer_addr(w_idx_next)),
    .i_wdata  (CMD_DATA),
    .o_rdata  (w_rdata),
    .o_rvalid (w_rvalid),
    .o_done   (w_xfer_done),
    .bus      (bus)
  );

  assign ram_addr  = r_ram_addr;
  assign ram_wdata = w_rdata;
  assign ram_we    = w_rvalid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_rtc_lectura_seq.sv
// Scoreboard bench for rtc_lectura_seq. Stimulus pushes the expected RAM
// writes and done pulse (with their cycle numbers) into a queue; an event
// monitor pops and compares whenever ram_we or done is seen, and a bus
// monitor checks phase lengths, gaps and phase contents.
module tb_rtc_lectura_seq;

  typedef struct {
    bit         is_done;
    int         slot;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we, busy, done;

  rtc_lectura_seq_if bus ();

  rtc_lectura_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .busy      (busy),
    .done      (done)
  );

  // Hand-computed expectations: addresses per transaction, bytes per slot.
  logic [7:0] exp_addr [10] = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24,
                                8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] exp_data [9]  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14,
                                8'h15, 8'h16, 8'h17, 8'h18};

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, req);
    end
  endtask

  // RTC model: remembers the address phase, returns 0x10+slot while rd is
  // low and a junk byte otherwise, so a mistimed sample is visible.
  function automatic logic [7:0] slot_of(input logic [7:0] a);
    case (a)
      8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26: slot_of = a - 8'h21;
      8'h41, 8'h42, 8'h43:                      slot_of = a - 8'h41 + 8'd6;
      default:                                  slot_of = 8'h0F;
    endcase
  endfunction

  logic [7:0] model_addr = 8'h00;
  always @(negedge clk) begin
    if (bus.cs === 1'b0 && bus.a_d === 1'b0) model_addr <= bus.ad_out;
    if (bus.rd === 1'b0) bus.ad_in <= 8'h10 + slot_of(model_addr);
    else                 bus.ad_in <= 8'hEE;
  end

  // Event monitor (scoreboard side).
  always @(negedge clk) begin
    if (ram_we === 1'b1 || done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event @cyc %0d: we=%b done=%b addr=%0h data=%0h",
                 cyc, ram_we, done, ram_addr, ram_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", 32'(done), 32'(mon_e.is_done));
        check("event_cycle", cyc, mon_e.cyc);
        if (!mon_e.is_done) begin
          check("ram_addr", 32'(ram_addr), mon_e.slot);
          check("ram_wdata", 32'(ram_wdata), 32'(mon_e.data));
        end else begin
          check("busy_in_fin", 32'(busy), 32'd0);
        end
      end
    end
  end

  // Bus monitor: phase lengths, gaps and per-phase contents.
  logic prev_cs = 1'b1;
  int   low_len = 0, high_len = 0, ph_no = 0;
  always @(negedge clk) begin
    if (bus.rd === 1'b0) begin
      check("oe_while_rd", 32'(bus.ad_oe), 32'd0);
      check("wr_while_rd", 32'(bus.wr), 32'd1);
    end
    if (prev_cs === 1'b1 && bus.cs === 1'b0) begin
      if (high_len != 0) check("gap_len", high_len, 2);
      if (ph_no < 20) begin
        if (ph_no % 2 == 0) begin
          check("addr_phase", {bus.a_d, bus.rd, bus.wr, bus.ad_oe}, 4'b0101);
          check("addr_byte", 32'(bus.ad_out), 32'(exp_addr[ph_no / 2]));
        end else if (ph_no == 1) begin
          check("cmd_phase", {bus.a_d, bus.rd, bus.wr, bus.ad_oe}, 4'b1101);
          check("cmd_byte", 32'(bus.ad_out), 32'h00);
        end else begin
          check("read_phase", {bus.a_d, bus.rd, bus.wr, bus.ad_oe}, 4'b1010);
        end
      end else begin
        check("phase_count", ph_no, 19);
      end
      ph_no++;
      low_len = 1;
    end else if (bus.cs === 1'b0) begin
      low_len++;
    end
    if (prev_cs === 1'b0 && bus.cs === 1'b1 && busy === 1'b1) check("phase_len", low_len, 8);
    if (busy !== 1'b1) begin
      high_len = 0;
      ph_no    = 0;
    end else if (bus.cs === 1'b1) begin
      high_len = (prev_cs === 1'b0) ? 1 : high_len + 1;
    end
    prev_cs = bus.cs;
  end

  // Call at a negedge: start is high for this cycle and sampled at its end.
  task automatic issue_start(output int k);
    k = cyc;
    for (int s = 0; s < 9; s++)
      exp_q.push_back('{1'b0, s, exp_data[s], k + 39 + 20 * s});
    exp_q.push_back('{1'b1, 0, 8'h00, k + 201});
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulse_start_at(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        d = cyc;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL done_timeout @cyc %0d: no done within 400 cycles", cyc);
  endtask

  initial begin
    int   k, d;
    exp_t keep[$];

    // Reset, with a start coincident with reset that must be ignored.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("reset_state",
          {bus.cs, bus.rd, bus.wr, bus.a_d, bus.ad_oe, bus.ad_out, ram_addr, ram_wdata, ram_we, busy, done},
          {3'b111, 2'b00, 8'h00, 4'h0, 8'h00, 3'b000});
    start = 1'b0;
    reset = 1'b0;

    // Nominal run, start at cycle 5, done expected at 206.
    while (cyc < 5) @(negedge clk);
    issue_start(k);
    @(negedge clk);
    check("busy_rise", {busy, bus.cs, bus.a_d}, 3'b100);
    wait_done(d);
    check("done_cycle_nominal", d, 206);

    // Back-to-back: start in the IDLE cycle after done, plus ignored starts
    // mid-run and during FIN.
    @(negedge clk);
    check("queue_drained_1", exp_q.size(), 0);
    issue_start(k);
    pulse_start_at(k + 50);
    pulse_start_at(k + 120);
    pulse_start_at(k + 201);
    repeat (5) @(negedge clk);
    check("idle_after_fin_start", {busy, bus.cs}, 2'b01);
    check("queue_drained_2", exp_q.size(), 0);

    // Reset during cycle 100 of a run: bus released on the next cycle and
    // all later strobes dropped.
    issue_start(k);
    while (cyc < k + 100) @(negedge clk);
    keep = {};
    foreach (exp_q[i]) if (exp_q[i].cyc <= k + 100) keep.push_back(exp_q[i]);
    exp_q = keep;
    reset = 1'b1;
    @(negedge clk);
    check("reset_release",
          {bus.cs, bus.rd, bus.wr, bus.a_d, bus.ad_oe, ram_we, busy, done},
          8'b11100000);
    reset = 1'b0;
    repeat (250) @(negedge clk);
    check("queue_after_reset", exp_q.size(), 0);

    // A fresh start after the reset completes normally.
    issue_start(k);
    wait_done(d);
    check("done_cycle_after_reset", d, k + 201);
    repeat (3) @(negedge clk);
    check("queue_drained_3", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
